// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory:
// the filler instruction, the loader state encoding and the word-index calculation.
package imem_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    // Index is computed at 64 bits so out-of-range and below-base addresses stay visible.
    function automatic logic [63:0] calc_index(input logic [63:0] pc, input logic [63:0] base);
        logic [63:0] offset;
        offset = pc - base;
        return offset >> 2;
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// LOAD/RUN controller for the instruction memory: owns the saturating load counter
// and produces the array write strobe and write address.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_valid,
    input  logic                     ld_done,
    output logic                     ld_ready,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic                     run
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    imem_state_t      state;
    imem_state_t      next_state;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // A write that coincides with ld_done is still taken before moving to RUN.
    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        wr_en      = 1'b0;
        run        = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                wr_en    = ld_valid && (count_q < FULL);
                if (ld_done) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (wr_en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign ld_count = count_q;
    assign wr_addr  = count_q[ADDR_W-1:0];

endmodule

// File: rtl/instr_mem_sync.sv
// Run-time loadable, synchronous-read instruction memory with a 1-cycle fetch response.
// Optional IMEM_BOUNDS_CHECK_EN faults fetches below BASE_ADDR or beyond DEPTH words.
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 64,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IMEM_NOP)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   ld_done,
    output logic                   ld_ready,
    output logic [$clog2(DEPTH):0] ld_count,
    input  logic                   req_valid,
    input  logic [XLEN-1:0]        pc,
    output logic                   req_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   rsp_valid,
    output logic [XLEN-1:0]        rsp_instr,
    output logic [XLEN-1:0]        rsp_pc,
    output logic                   rsp_fault
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   ram_q;
    logic              use_mem;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              run;

    logic [63:0]       full_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              filled;
    logic              fault;
    logic              hit;
    logic              accept;

    imem_load_ctrl #(
        .DEPTH(DEPTH)
    ) u_load_ctrl (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_done  (ld_done),
        .ld_ready (ld_ready),
        .ld_count (ld_count),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .run      (run)
    );

    assign full_idx   = calc_index(64'(pc), 64'(BASE_ADDR));
    assign rd_addr    = full_idx[ADDR_W-1:0];
    assign misaligned = (pc[1:0] != 2'b00);

`ifdef IMEM_BOUNDS_CHECK_EN
    assign out_of_range = (pc < BASE_ADDR) || (full_idx >= 64'(DEPTH));
    assign filled       = (full_idx < 64'(ld_count));
`else
    // Without bounds checking the index wraps modulo DEPTH.
    logic unused_idx_bits;
    assign unused_idx_bits = ^full_idx[63:ADDR_W];
    assign out_of_range    = 1'b0;
    assign filled          = ({1'b0, rd_addr} < ld_count);
`endif

    assign fault     = misaligned || out_of_range;
    assign hit       = !fault && filled;
    assign req_ready = run && !stall;
    assign accept    = req_valid && req_ready && !flush;

    // Block-RAM style array: the read port only fires on an accepted fetch, so a stall never re-reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= ld_data;
        end
        if (accept) begin
            ram_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_pc    <= '0;
            rsp_fault <= 1'b0;
            use_mem   <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (stall) begin
            rsp_valid <= rsp_valid;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_pc    <= pc;
            rsp_fault <= fault;
            use_mem   <= hit;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

    // The RAM output register has no reset, so the filler word is selected until a real hit.
    assign rsp_instr = use_mem ? ram_q : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: directed scenarios followed by randomized traffic
// scored against an array-based reference model (honours IMEM_BOUNDS_CHECK_EN).
module tb_instr_mem_sync;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic                   clk;
    logic                   reset;
    logic                   ld_valid;
    logic [XLEN-1:0]        ld_data;
    logic                   ld_done;
    logic                   ld_ready;
    logic [$clog2(DEPTH):0] ld_count;
    logic                   req_valid;
    logic [XLEN-1:0]        pc;
    logic                   req_ready;
    logic                   stall;
    logic                   flush;
    logic                   rsp_valid;
    logic [XLEN-1:0]        rsp_instr;
    logic [XLEN-1:0]        rsp_pc;
    logic                   rsp_fault;

    int checks;
    int passes;

    bit          m_load;
    int          m_count;
    logic [31:0] m_mem [DEPTH];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_fault;

    logic [31:0] prog [6];
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [31:0] word0;

    instr_mem_sync #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .NOP_INSTR (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .ld_ready  (ld_ready),
        .ld_count  (ld_count),
        .req_valid (req_valid),
        .pc        (pc),
        .req_ready (req_ready),
        .stall     (stall),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Reference fetch: byte address -> word index, with the filler and fault rules.
    function automatic void modelFetch(input logic [31:0] p, output logic [31:0] ins, output logic f);
        longint unsigned idx;
        bit mis;
        bit oob;
        idx = longint'(p - BASE) / 4;
        mis = (p % 4) != 0;
        oob = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
        if (p < BASE || idx >= DEPTH) oob = 1'b1;
`else
        idx = idx % DEPTH;
`endif
        f   = mis || oob;
        ins = (f || idx >= longint'(m_count)) ? NOP : m_mem[idx];
    endfunction

    task automatic checkOutput();
        checkVal("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        checkVal("rsp_instr", rsp_instr, m_instr);
        checkVal("rsp_pc",    rsp_pc,    m_pc);
        checkVal("rsp_fault", 32'(rsp_fault), 32'(m_fault));
        checkVal("ld_count",  32'(ld_count),  32'(m_count));
    endtask

    task automatic applyStimulus(input bit rst, input bit rv, input logic [31:0] p, input bit st,
                                 input bit fl, input bit lv, input logic [31:0] ld, input bit dn);
        bit acc;
        reset     = rst;
        req_valid = rv;
        pc        = p;
        stall     = st;
        flush     = fl;
        ld_valid  = lv;
        ld_data   = ld;
        ld_done   = dn;
        #1;
        checkVal("ld_ready",  32'(ld_ready),  32'(m_load));
        checkVal("req_ready", 32'(req_ready), 32'(!m_load && !st));
        if (rst) begin
            m_load  = 1'b1;
            m_count = 0;
            m_valid = 1'b0;
            m_instr = NOP;
            m_pc    = '0;
            m_fault = 1'b0;
        end else begin
            acc = !m_load && rv && !st;
            if (fl) begin
                m_valid = 1'b0;
            end else if (st) begin
                m_valid = m_valid;
            end else if (acc) begin
                m_valid = 1'b1;
                m_pc    = p;
                modelFetch(p, m_instr, m_fault);
            end else begin
                m_valid = 1'b0;
            end
            if (m_load) begin
                if (lv && m_count < DEPTH) begin
                    m_mem[m_count] = ld;
                    m_count++;
                end
                if (dn) m_load = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic fetch(input logic [31:0] p);
        applyStimulus(0, 1, p, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic loadWord(input logic [31:0] d, input bit done);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, d, done);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        prog[0] = 32'hFFC4_A303;
        prog[1] = 32'h00A0_0093;
        prog[2] = 32'h0010_8113;
        prog[3] = 32'h0020_81B3;
        prog[4] = 32'h0041_8233;
        prog[5] = 32'hFE42_06E3;

        reset = 1'b1; req_valid = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_load = 1'b1; m_count = 0; m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_fault = 1'b0;
        checkOutput();
        $display("[TB] reset state checked");

        // Six-word program; last word written together with ld_done.
        for (int i = 0; i < 6; i++) loadWord(prog[i], i == 5);
        fetch(32'h14);
        checkVal("tp_fetch14_instr", rsp_instr, 32'hFE42_06E3);
        checkVal("tp_fetch14_pc", rsp_pc, 32'h14);
        fetch(32'h18);
        fetch(32'h6);
        checkVal("tp_misaligned_fault", 32'(rsp_fault), 32'd1);
        idle();

        // Four-word program: fetch past the loaded region gives the filler without a fault.
        doReset();
        for (int i = 0; i < 4; i++) loadWord(prog[i], 1'b0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 1);
        fetch(32'h10);
        checkVal("tp_unloaded_instr", rsp_instr, NOP);
        checkVal("tp_unloaded_fault", 32'(rsp_fault), 32'd0);
        fetch(32'h6);
        checkVal("tp_mis_instr", rsp_instr, NOP);
        checkVal("tp_mis_fault", 32'(rsp_fault), 32'd1);

        // Stall holds the response while pc changes underneath.
        fetch(32'h0);
        held_instr = rsp_instr;
        held_pc    = rsp_pc;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'($urandom_range(1, 15)) << 2, 1, 0, 0, 32'h0, 0);
            checkVal("stall_hold_instr", rsp_instr, held_instr);
            checkVal("stall_hold_pc", rsp_pc, held_pc);
        end
        fetch(32'h8);
        checkVal("after_stall_instr", rsp_instr, prog[2]);

        // Flush kills a same-cycle accept, and wins over stall.
        applyStimulus(0, 1, 32'h4, 0, 1, 0, 32'h0, 0);
        checkVal("flush_kill_valid", 32'(rsp_valid), 32'd0);
        fetch(32'h4);
        applyStimulus(0, 1, 32'hC, 1, 1, 0, 32'h0, 0);
        checkVal("flush_stall_valid", 32'(rsp_valid), 32'd0);

        // Address one past the array.
        fetch(32'h100);
`ifdef IMEM_BOUNDS_CHECK_EN
        checkVal("oob_instr", rsp_instr, NOP);
        checkVal("oob_fault", 32'(rsp_fault), 32'd1);
`else
        checkVal("wrap_instr", rsp_instr, prog[0]);
        checkVal("wrap_fault", 32'(rsp_fault), 32'd0);
`endif

        // Reset while running returns to loading.
        doReset();
        checkVal("rst_run_ld_ready", 32'(ld_ready), 32'd1);
        checkVal("rst_run_req_ready", 32'(req_ready), 32'd0);
        checkVal("rst_run_ld_count", 32'(ld_count), 32'd0);

        // Overfill: count saturates and the first DEPTH words survive.
        for (int i = 0; i < 70; i++) begin
            if (i == 0) word0 = $urandom;
            loadWord(i == 0 ? word0 : 32'($urandom), 1'b0);
        end
        checkVal("sat_ld_count", 32'(ld_count), 32'(DEPTH));
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        for (int i = 0; i < DEPTH; i++) fetch(32'(i) << 2);
        fetch(32'h0);
        checkVal("sat_word0", rsp_instr, word0);

        // Randomized traffic, including occasional resets and reloads.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rp;
            case ($urandom_range(0, 3))
                0:       rp = 32'($urandom_range(0, DEPTH - 1)) << 2;
                1:       rp = 32'($urandom_range(0, 4 * DEPTH + 64));
                2:       rp = 32'($urandom_range(0, 255)) << 2;
                default: rp = $urandom;
            endcase
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rp,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined RISC-V core, replacing the hard-coded combinational ROM.
- Contents are written at run time by a sequential loader port, so no RTL edit is needed per program.
- Fetch is a valid/ready request with 1-cycle latency, stall hold, flush kill, and fault reporting.
- Sits between the fetch-stage PC register and the IF/ID pipeline register.

Parameters:
- XLEN, 32, instruction/PC width.
- DEPTH, 64, number of instruction words (power of two, >=2).
- ADDR_W, $clog2(DEPTH), word-index width; derived, not overridden.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NOP_INSTR, 32'h0000_0013, filler word (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- ld_valid  in  1  loader write strobe; writes ld_data at mem[ld_count].
- ld_data  in  XLEN  word to load.
- ld_done  in  1  end of program load.
- ld_ready  out  1  high while in LOAD state.
- ld_count  out  ADDR_W+1  words loaded so far.
- req_valid  in  1  fetch request.
- pc  in  XLEN  fetch byte address.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- stall  in  1  hold response registers.
- flush  in  1  kill response and any request in same cycle.
- rsp_valid  out  1  response valid.
- rsp_instr  out  XLEN  fetched instruction.
- rsp_pc  out  XLEN  PC of the response.
- rsp_fault  out  1  misaligned / out-of-range fetch.

Behaviour:
- States: LOAD, RUN.
- Reset:
  - Enters LOAD; ld_count=0.
  - rsp_valid=0, rsp_instr=NOP_INSTR, rsp_pc=0, rsp_fault=0.
  - Memory array is not cleared. Reset mid-operation (in either state) returns to LOAD and restarts loading at word 0.
- LOAD:
  - ld_ready=1, req_ready=0; req_valid is ignored.
  - ld_valid && ld_count<DEPTH: write mem[ld_count], then ld_count+1.
  - ld_valid when ld_count==DEPTH: write dropped; ld_count saturates.
  - ld_done: RUN next cycle. If ld_valid is asserted in the same cycle, the write is still performed.
- RUN:
  - ld_ready=0; ld_valid and ld_done are ignored.
  - req_ready = !stall.
- Index = (pc - BASE_ADDR) >> 2.
- Response register update, in priority order:
  1. flush: rsp_valid<=0 next cycle. Any same-cycle accepted request is discarded. Flush overrides stall.
  2. stall: all rsp_* hold their values.
  3. accept (req_valid && req_ready): next cycle rsp_valid=1, rsp_pc=pc.
     - rsp_instr = mem[index] if index < ld_count, otherwise NOP_INSTR.
     - Misaligned pc (pc[1:0]!=0): rsp_instr=NOP_INSTR, rsp_fault=1.
     - rsp_fault=0 otherwise (subject to the bounds rule below).
  4. otherwise: rsp_valid<=0; rsp_instr, rsp_pc and rsp_fault keep their last values.
- Latency: exactly 1 cycle from accept to rsp_valid. Back-to-back accepts give one response per cycle.
- Array read is synchronous (maps to block RAM). Stall must not re-read.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Defined:
  - pc < BASE_ADDR, or full index >= DEPTH, gives rsp_instr=NOP_INSTR and rsp_fault=1.
- Undefined:
  - Index is truncated to ADDR_W bits (wraps modulo DEPTH).
  - rsp_fault reflects misalignment only.
- The ld_count filler rule applies in both builds.

Decomposition:
- imem_pkg holds:
  - NOP_INSTR constant.
  - imem_state_t enum (LOAD, RUN).
  - index-calculation function.
- One sub-module, imem_load_ctrl: the LOAD/RUN FSM plus the saturating ld_count counter; drives the write enable and write address.
- instr_mem_sync holds the array and the response pipeline register.

Test Plan:
- Reset, load 6 words (0xFFC4A303 … 0xFE4206E3), assert ld_done; fetch pc=0x14 → next cycle rsp_valid=1, rsp_instr=0xFE4206E3, rsp_pc=0x14, rsp_fault=0.
- Load 4 words, fetch pc=0x10 → rsp_instr=0x00000013, rsp_fault=0. Fetch pc=0x6 → rsp_instr=0x00000013, rsp_fault=1.
- Fetch pc=0x0, then assert stall for 3 cycles while pc changes → rsp_* constant for 3 cycles and req_ready=0; next accept proceeds normally.
- Accept pc=0x4 with flush in the same cycle → rsp_valid=0 next cycle. Flush+stall together → rsp_valid=0.
- DEPTH=64: 70 ld_valid pulses → ld_count=64, mem[0..63] intact. Reset during RUN → ld_ready=1, req_ready=0, ld_count=0.
- IMEM_BOUNDS_CHECK_EN defined: pc=0x100 → NOP, rsp_fault=1. Undefined: pc=0x100 returns mem[0], rsp_fault=0.
